// File: rtl/elastic_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : elastic_buffer_pkg
// Purpose  : Shared symbol constants, FSM state type and Gray helpers for the
//            elastic buffer write and read controllers.
// Revision : 1.0 - initial release
// ============================================================================
package elastic_buffer_pkg;

    localparam logic [9:0] K28_5_POS = 10'b0011111010;
    localparam logic [9:0] K28_5_NEG = 10'b1100000101;
    localparam logic [9:0] K28_0_POS = 10'b0011110100;
    localparam logic [9:0] K28_0_NEG = 10'b1100001011;

    typedef enum logic [0:0] {
        ALIGN = 1'b0,
        RUN   = 1'b1
    } state_t;

    // Width-agnostic: callers zero-extend into 32 bits and size-cast the result.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        for (int i = 0; i < 32; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

endpackage : elastic_buffer_pkg
`default_nettype wire

// File: rtl/elastic_buffer_write_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : elastic_buffer_write_ctrl_if
// Purpose  : Symbol input, memory write port and pointer exchange signals of
//            the elastic buffer write controller. ELASTIC_BUFFER_STATS_EN adds
//            the statistics outputs.
// Revision : 1.0 - initial release
// ============================================================================
interface elastic_buffer_write_ctrl_if #(
    parameter int ADDRESS_WIDTH = 4
);
    logic [9:0]             data_in;
    logic                   symbol_valid;
    logic [ADDRESS_WIDTH:0] read_pointer_gray;
    logic [ADDRESS_WIDTH-1:0] write_pointer;
    logic [9:0]             mem_data;
    logic [ADDRESS_WIDTH:0] write_pointer_gray;
    logic                   aligned;
    logic                   skp_deleted;
    logic                   overflow_error;
`ifdef ELASTIC_BUFFER_STATS_EN
    logic [15:0]            skp_delete_count;
    logic [ADDRESS_WIDTH:0] max_fill;

    modport master (
        output data_in, symbol_valid, read_pointer_gray,
        input  write_pointer, mem_data, write_pointer_gray, aligned,
               skp_deleted, overflow_error, skp_delete_count, max_fill
    );
    modport slave (
        input  data_in, symbol_valid, read_pointer_gray,
        output write_pointer, mem_data, write_pointer_gray, aligned,
               skp_deleted, overflow_error, skp_delete_count, max_fill
    );
`else
    modport master (
        output data_in, symbol_valid, read_pointer_gray,
        input  write_pointer, mem_data, write_pointer_gray, aligned,
               skp_deleted, overflow_error
    );
    modport slave (
        input  data_in, symbol_valid, read_pointer_gray,
        output write_pointer, mem_data, write_pointer_gray, aligned,
               skp_deleted, overflow_error
    );
`endif
endinterface : elastic_buffer_write_ctrl_if
`default_nettype wire

// File: rtl/gray_pointer_sync.sv
`default_nettype none
// ============================================================================
// Module   : gray_pointer_sync
// Purpose  : Two-flop synchroniser for a Gray-coded pointer from the other
//            clock domain, followed by conversion back to binary.
// Revision : 1.0 - initial release
// ============================================================================
module gray_pointer_sync
    import elastic_buffer_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic [WIDTH-1:0] i_gray,
    output logic      [WIDTH-1:0] o_bin
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_gray;
            r_sync <= r_meta;
        end
    end

    assign o_bin = WIDTH'(gray2bin(32'(r_sync)));

endmodule : gray_pointer_sync
`default_nettype wire

// File: rtl/elastic_buffer_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : elastic_buffer_write_ctrl
// Purpose  : Recovered-clock write side of the RX elastic buffer: comma
//            alignment, SKP deletion near full, Gray pointer exchange.
//            Optional statistics outputs under ELASTIC_BUFFER_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module elastic_buffer_write_ctrl
    import elastic_buffer_pkg::*;
#(
    parameter int BUFFER_DEPTH   = 16,
    parameter int ADDRESS_WIDTH  = 4,
    parameter int HIGH_WATERMARK = 12
) (
    input  wire logic recovered_clock,
    input  wire logic recovered_reset,
    elastic_buffer_write_ctrl_if.slave bus
);

    localparam int PW = ADDRESS_WIDTH + 1;
    localparam int FW = ADDRESS_WIDTH + 2;

    state_t         r_state;
    state_t         w_state_next;
    logic [PW-1:0]  r_wptr;
    logic [PW-1:0]  w_wptr_next;
    logic [PW-1:0]  r_wgray;
    logic [PW-1:0]  w_rptr;
    logic [PW-1:0]  w_fill;
    logic [FW-1:0]  w_eff_fill;
    logic [9:0]     r_mem_data;
    logic           r_keep_q;
    logic           r_skp_deleted;
    logic           r_overflow;
    logic           w_keep;
    logic           w_skp_drop;
    logic           w_ovf_set;
    logic           w_is_comma;
    logic           w_is_skp;

    gray_pointer_sync #(
        .WIDTH (PW)
    ) u_rptr_sync (
        .clk    (recovered_clock),
        .rst_n  (recovered_reset),
        .i_gray (bus.read_pointer_gray),
        .o_bin  (w_rptr)
    );

    assign w_is_comma = (bus.data_in == K28_5_POS) || (bus.data_in == K28_5_NEG);
    assign w_is_skp   = (bus.data_in == K28_0_POS) || (bus.data_in == K28_0_NEG);

    // The symbol held in r_mem_data is counted as occupying the buffer if it
    // will be committed at the coming edge.
    assign w_wptr_next = r_wptr + PW'(r_keep_q);
    assign w_fill      = r_wptr - w_rptr;
    assign w_eff_fill  = FW'(w_fill) + FW'(r_keep_q);

    always_comb begin
        w_state_next = r_state;
        w_keep       = 1'b0;
        w_skp_drop   = 1'b0;
        w_ovf_set    = 1'b0;
        case (r_state)
            ALIGN: begin
                if (bus.symbol_valid && w_is_comma) begin
                    w_keep       = 1'b1;
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (bus.symbol_valid) begin
                    if (w_eff_fill == FW'(BUFFER_DEPTH)) begin
                        w_ovf_set    = 1'b1;
                        w_state_next = ALIGN;
                    end else if (w_is_skp && (w_eff_fill >= FW'(HIGH_WATERMARK))) begin
                        w_skp_drop = 1'b1;
                    end else begin
                        w_keep = 1'b1;
                    end
                end
            end
            default: w_state_next = ALIGN;
        endcase
    end

    always_ff @(posedge recovered_clock or negedge recovered_reset) begin
        if (!recovered_reset) begin
            r_state       <= ALIGN;
            r_wptr        <= '0;
            r_wgray       <= '0;
            r_mem_data    <= '0;
            r_keep_q      <= 1'b0;
            r_skp_deleted <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_wptr        <= w_wptr_next;
            r_wgray       <= PW'(bin2gray(32'(w_wptr_next)));
            r_mem_data    <= bus.data_in;
            r_keep_q      <= w_keep;
            r_skp_deleted <= w_skp_drop;
            r_overflow    <= r_overflow | w_ovf_set;
        end
    end

    assign bus.write_pointer      = r_wptr[ADDRESS_WIDTH-1:0];
    assign bus.mem_data           = r_mem_data;
    assign bus.write_pointer_gray = r_wgray;
    assign bus.aligned            = (r_state == RUN);
    assign bus.skp_deleted        = r_skp_deleted;
    assign bus.overflow_error     = r_overflow;

`ifdef ELASTIC_BUFFER_STATS_EN
    logic [15:0]   r_skp_cnt;
    logic [PW-1:0] r_max_fill;

    always_ff @(posedge recovered_clock or negedge recovered_reset) begin
        if (!recovered_reset) begin
            r_skp_cnt  <= '0;
            r_max_fill <= '0;
        end else begin
            if (w_skp_drop && (r_skp_cnt != 16'hFFFF)) begin
                r_skp_cnt <= r_skp_cnt + 16'd1;
            end
            // Clamp so a fill beyond the port range never wraps to a small value.
            if (w_eff_fill > FW'(r_max_fill)) begin
                r_max_fill <= (w_eff_fill > FW'({PW{1'b1}})) ? {PW{1'b1}} : PW'(w_eff_fill);
            end
        end
    end

    assign bus.skp_delete_count = r_skp_cnt;
    assign bus.max_fill         = r_max_fill;
`endif

endmodule : elastic_buffer_write_ctrl
`default_nettype wire

// File: tb/tb_elastic_buffer_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_elastic_buffer_write_ctrl
// Purpose  : Self-checking bench: vector table, directed corner sequences and
//            randomized traffic against a symbol-counting reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_elastic_buffer_write_ctrl;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    elastic_buffer_write_ctrl_if #(.ADDRESS_WIDTH(4)) eb_if();

    elastic_buffer_write_ctrl #(
        .BUFFER_DEPTH   (16),
        .ADDRESS_WIDTH  (4),
        .HIGH_WATERMARK (12)
    ) dut (
        .recovered_clock (clk),
        .recovered_reset (rst_n),
        .bus             (eb_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory behaviour seen by the controller's write port.
    logic [9:0] tbmem [16];
    always @(posedge clk) tbmem[eb_if.write_pointer] <= eb_if.mem_data;

    // Reference model: committed symbol count, pending symbol, reader count.
    int m_wptr, m_pend, m_pend_data, m_run, m_ovf, m_skp_cnt, m_max;
    int rd_cnt, h1, h2, rd_mode;

    typedef struct {
        logic [9:0] d;
        bit         v;
        int         wp;
        bit         al;
    } vec_t;
    vec_t tbl[9];

    function automatic bit is_comma(input logic [9:0] d);
        return (d == 10'b0011111010) || (d == 10'b1100000101);
    endfunction

    function automatic bit is_skp(input logic [9:0] d);
        return (d == 10'b0011110100) || (d == 10'b1100001011);
    endfunction

    function automatic int gray(input int b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_wptr = 0; m_pend = 0; m_pend_data = 0; m_run = 0; m_ovf = 0;
        m_skp_cnt = 0; m_max = 0; rd_cnt = 0; h1 = 0; h2 = 0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_wp"},   int'(eb_if.write_pointer), 0);
        chk({tag, "_gray"}, int'(eb_if.write_pointer_gray), 0);
        chk({tag, "_mem"},  int'(eb_if.mem_data), 0);
        chk({tag, "_al"},   int'(eb_if.aligned), 0);
        chk({tag, "_skp"},  int'(eb_if.skp_deleted), 0);
        chk({tag, "_ovf"},  int'(eb_if.overflow_error), 0);
`ifdef ELASTIC_BUFFER_STATS_EN
        chk({tag, "_scnt"}, int'(eb_if.skp_delete_count), 0);
        chk({tag, "_maxf"}, int'(eb_if.max_fill), 0);
`endif
    endtask

    // Asynchronous reset asserted away from any clock edge.
    task automatic mid_reset();
        @(negedge clk);
        #2;
        eb_if.symbol_valid      = 1'b0;
        eb_if.data_in           = '0;
        eb_if.read_pointer_gray = '0;
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic step(input logic [9:0] d, input bit v);
        int fill, eff, keep, skp_e, newp, old_p, old_pend, old_data;
        @(negedge clk);
        if (rd_mode == 1) rd_cnt = m_wptr;
        else if (rd_mode == 2 && rd_cnt != m_wptr && $urandom_range(0, 1) == 1)
            rd_cnt = (rd_cnt + 1) % 32;
        eb_if.data_in           = d;
        eb_if.symbol_valid      = v;
        eb_if.read_pointer_gray = 5'(gray(rd_cnt));

        // The controller sees the reader position from two cycles earlier.
        fill  = (m_wptr - h2 + 32) % 32;
        eff   = fill + m_pend;
        keep  = 0;
        skp_e = 0;
        if (m_run == 0) begin
            if (v && is_comma(d)) begin keep = 1; m_run = 1; end
        end else if (v) begin
            if (eff == 16) begin m_ovf = 1; m_run = 0; end
            else if (is_skp(d) && eff >= 12) skp_e = 1;
            else keep = 1;
        end
        if (eff > m_max) m_max = (eff > 31) ? 31 : eff;
        if (skp_e == 1 && m_skp_cnt < 65535) m_skp_cnt++;
        old_p       = m_wptr;
        old_pend    = m_pend;
        old_data    = m_pend_data;
        m_wptr      = (m_wptr + m_pend) % 32;
        newp        = m_wptr;
        m_pend      = keep;
        m_pend_data = int'(d);
        h2 = h1;
        h1 = rd_cnt;

        @(posedge clk);
        #1;
        chk("wp",   int'(eb_if.write_pointer), newp % 16);
        chk("gray", int'(eb_if.write_pointer_gray), gray(newp));
        chk("mem_data", int'(eb_if.mem_data), int'(d));
        chk("aligned",  int'(eb_if.aligned), m_run);
        chk("skp_del",  int'(eb_if.skp_deleted), skp_e);
        chk("ovf",      int'(eb_if.overflow_error), m_ovf);
        if (old_pend == 1) chk("commit", int'(tbmem[old_p % 16]), old_data);
`ifdef ELASTIC_BUFFER_STATS_EN
        chk("skp_cnt",  int'(eb_if.skp_delete_count), m_skp_cnt);
        chk("max_fill", int'(eb_if.max_fill), m_max);
`endif
    endtask

    initial begin
        logic [9:0] d;
        int         sel;
        int         prev_wp;
        int         wrapped;
        total = 0;
        bad   = 0;
        rd_mode = 0;
        model_clear();

        tbl[0] = '{10'h155, 1'b1, 0, 1'b0};
        tbl[1] = '{10'h0AA, 1'b1, 0, 1'b0};
        tbl[2] = '{10'h3C3, 1'b1, 0, 1'b0};
        tbl[3] = '{10'h0F4, 1'b1, 0, 1'b0};
        tbl[4] = '{10'h1E1, 1'b1, 0, 1'b0};
        tbl[5] = '{10'h0FA, 1'b1, 0, 1'b1};
        tbl[6] = '{10'h2AA, 1'b1, 1, 1'b1};
        tbl[7] = '{10'h000, 1'b0, 2, 1'b1};
        tbl[8] = '{10'h000, 1'b0, 2, 1'b1};

        eb_if.data_in           = '0;
        eb_if.symbol_valid      = 1'b0;
        eb_if.read_pointer_gray = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Alignment table: five non-commas, then a comma committed at address 0.
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].d, tbl[i].v);
            chk("tbl_wp", int'(eb_if.write_pointer), tbl[i].wp);
            chk("tbl_al", int'(eb_if.aligned), int'(tbl[i].al));
            if (i == 6) chk("tbl_comma_at_0", int'(tbmem[0]), 10'h0FA);
        end

        // Lockstep reader: write pointer runs through the wrap.
        rd_mode = 1;
        wrapped = 0;
        for (int i = 0; i < 20; i++) begin
            prev_wp = int'(eb_if.write_pointer);
            step(10'h2AA + 10'(i), 1'b1);
            if (prev_wp == 15 && eb_if.write_pointer == 4'd0) wrapped = 1;
        end
        chk("wrap_seen", wrapped, 1);

        // SKP at fill 12 is deleted and its slot reused.
        mid_reset();
        rd_mode = 0;
        step(10'h0FA, 1'b1);
        for (int i = 0; i < 11; i++) step(10'h100 + 10'(i), 1'b1);
        step(10'h0F4, 1'b1);
        chk("skp12_pulse", int'(eb_if.skp_deleted), 1);
        chk("skp12_wp", int'(eb_if.write_pointer), 12);
        step(10'h1A5, 1'b1);
        chk("skp12_wp_hold", int'(eb_if.write_pointer), 12);
        step(10'h000, 1'b0);
        chk("skp12_reuse", int'(tbmem[12]), 10'h1A5);

        // SKP at fill 11 is kept.
        mid_reset();
        step(10'h305, 1'b1);
        for (int i = 0; i < 10; i++) step(10'h100 + 10'(i), 1'b1);
        step(10'h30B, 1'b1);
        chk("skp11_no_pulse", int'(eb_if.skp_deleted), 0);
        step(10'h000, 1'b0);
        chk("skp11_kept", int'(tbmem[11]), 10'h30B);

        // Overflow with a frozen reader; sticky across realignment.
        mid_reset();
        step(10'h0FA, 1'b1);
        for (int i = 0; i < 17; i++) step(10'h100 + 10'(i), 1'b1);
        chk("ovf_set", int'(eb_if.overflow_error), 1);
        chk("ovf_unaligned", int'(eb_if.aligned), 0);
        step(10'h0FA, 1'b1);
        chk("ovf_realign", int'(eb_if.aligned), 1);
        step(10'h000, 1'b0);
        chk("ovf_sticky", int'(eb_if.overflow_error), 1);
        mid_reset();
        step(10'h155, 1'b1);
        chk("post_rst_unaligned", int'(eb_if.aligned), 0);
        chk("post_rst_ovf", int'(eb_if.overflow_error), 0);

        // Randomized traffic, reader alternating between stalled and running.
        for (int i = 0; i < 400; i++) begin
            rd_mode = (((i / 40) % 2) == 0) ? 2 : 0;
            if (i == 200) mid_reset();
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      d = ($urandom_range(0, 1) == 1) ? 10'h0FA : 10'h305;
            else if (sel <= 3) d = ($urandom_range(0, 1) == 1) ? 10'h0F4 : 10'h30B;
            else               d = 10'($urandom);
            step(d, $urandom_range(0, 3) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_elastic_buffer_write_ctrl
`default_nettype wire
